// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state type and default bus widths for the SDRAM
// port arbiter that sits in front of the HPS FPGA-to-SDRAM bridge.
package sdram_arb_pkg;

  // Grant owner of the shared Avalon-MM port
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD,
    ARB_WR
  } arb_state_t;

  localparam int SDRAM_ADDR_W  = 27;
  localparam int SDRAM_BURST_W = 8;

endpackage

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one Avalon-MM SDRAM port between the frame
// reader (display, fixed priority) and the frame writer (ingest).
// Write bursts keep the grant until their last beat is accepted; read data
// goes straight back to the reader since the writer never reads.
// Optional macro SDRAM_ARB_FAIR_EN: after MAX_RD_STREAK accepted reads in a
// row, a pending write is forced in so the writer cannot starve.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int SDRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH       = SDRAM_ADDR_W,
  parameter int BURST_WIDTH      = SDRAM_BURST_W,
  parameter int MAX_RD_STREAK    = 64
) (
  input  logic                          sdram_clk,
  input  logic                          rst,
  // frame reader
  input  logic [ADDR_WIDTH-1:0]         rd_address_i,
  input  logic [BURST_WIDTH-1:0]        rd_burstcount_i,
  input  logic                          rd_read_i,
  output logic                          rd_waitrequest_o,
  output logic [SDRAM_DATA_WIDTH-1:0]   rd_readdata_o,
  output logic                          rd_readdatavalid_o,
  // frame writer
  input  logic [ADDR_WIDTH-1:0]         wr_address_i,
  input  logic [BURST_WIDTH-1:0]        wr_burstcount_i,
  input  logic                          wr_write_i,
  input  logic [SDRAM_DATA_WIDTH-1:0]   wr_writedata_i,
  input  logic [SDRAM_DATA_WIDTH/8-1:0] wr_byteenable_i,
  output logic                          wr_waitrequest_o,
  // SDRAM slave port
  output logic [ADDR_WIDTH-1:0]         sdram_address_o,
  output logic [BURST_WIDTH-1:0]        sdram_burstcount_o,
  output logic                          sdram_read_o,
  output logic                          sdram_write_o,
  output logic [SDRAM_DATA_WIDTH-1:0]   sdram_writedata_o,
  output logic [SDRAM_DATA_WIDTH/8-1:0] sdram_byteenable_o,
  input  logic                          sdram_waitrequest_i,
  input  logic [SDRAM_DATA_WIDTH-1:0]   sdram_readdata_i,
  input  logic                          sdram_readdatavalid_i
);

  localparam logic [BURST_WIDTH-1:0] BEAT_ONE = BURST_WIDTH'(1);

  // A zero streak limit would make the fairness logic meaningless
  generate
    if (MAX_RD_STREAK < 1) begin : g_bad_streak
      $error("MAX_RD_STREAK must be at least 1");
    end
  endgenerate

  arb_state_t             state_reg;
  logic [BURST_WIDTH-1:0] beats_left_reg;
  logic [ADDR_WIDTH-1:0]  wr_addr_hold_reg;
  logic [BURST_WIDTH-1:0] wr_bc_hold_reg;

  logic                   force_wr;
  logic                   wr_accept;
  logic                   wr_first_beat;
  logic                   wr_last;
  logic [BURST_WIDTH-1:0] wr_burst_len;

  // beats_left == 0 while in WR means the first beat has not been taken yet
  assign wr_first_beat = (beats_left_reg == '0);
  assign wr_burst_len  = (wr_burstcount_i == '0) ? BEAT_ONE : wr_burstcount_i;
  assign wr_accept     = (state_reg == ARB_WR) && wr_write_i && !sdram_waitrequest_i;
  assign wr_last       = wr_accept &&
                         (wr_first_beat ? (wr_burst_len == BEAT_ONE)
                                        : (beats_left_reg == BEAT_ONE));

  // Read return path is shared and unconditional: the writer never reads
  assign rd_readdata_o      = sdram_readdata_i;
  assign rd_readdatavalid_o = sdram_readdatavalid_i;

`ifdef SDRAM_ARB_FAIR_EN
  localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

  logic [STREAK_W-1:0] rd_streak_reg;
  logic                rd_accept;

  assign rd_accept = (state_reg == ARB_RD) && rd_read_i && !force_wr && !sdram_waitrequest_i;
  // Streak is full and the writer is waiting: block the reader this cycle
  assign force_wr  = (state_reg == ARB_RD) && (rd_streak_reg == STREAK_MAX) && wr_write_i;

  // Count back-to-back accepted reads; cleared whenever the reader loses the port
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      rd_streak_reg <= '0;
    end else if ((state_reg != ARB_RD) || !rd_read_i || force_wr) begin
      rd_streak_reg <= '0;
    end else if (rd_accept && (rd_streak_reg != STREAK_MAX)) begin
      rd_streak_reg <= rd_streak_reg + STREAK_W'(1);
    end
  end
`else
  assign force_wr = 1'b0;
`endif

  // Slave-side mux, driven from the registered grant
  always_comb begin
    sdram_read_o       = 1'b0;
    sdram_write_o      = 1'b0;
    sdram_address_o    = '0;
    sdram_burstcount_o = '0;
    sdram_writedata_o  = '0;
    sdram_byteenable_o = '0;
    rd_waitrequest_o   = 1'b1;
    wr_waitrequest_o   = 1'b1;
    if (!rst) begin
      case (state_reg)
        ARB_RD: begin
          sdram_read_o       = rd_read_i && !force_wr;
          sdram_address_o    = rd_address_i;
          sdram_burstcount_o = rd_burstcount_i;
          rd_waitrequest_o   = sdram_waitrequest_i || force_wr;
        end
        ARB_WR: begin
          sdram_write_o      = wr_write_i;
          sdram_address_o    = wr_first_beat ? wr_address_i : wr_addr_hold_reg;
          sdram_burstcount_o = wr_first_beat ? wr_burstcount_i : wr_bc_hold_reg;
          sdram_writedata_o  = wr_writedata_i;
          sdram_byteenable_o = wr_byteenable_i;
          wr_waitrequest_o   = sdram_waitrequest_i;
        end
        default: ;
      endcase
    end
  end

  // Grant FSM plus write-burst beat tracking
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      state_reg        <= ARB_IDLE;
      beats_left_reg   <= '0;
      wr_addr_hold_reg <= '0;
      wr_bc_hold_reg   <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (rd_read_i) begin
            state_reg <= ARB_RD;
          end else if (wr_write_i) begin
            state_reg <= ARB_WR;
          end
        end
        ARB_RD: begin
          if (!rd_read_i) begin
            state_reg <= ARB_IDLE;
          end else if (force_wr) begin
            state_reg <= ARB_WR;
          end
        end
        ARB_WR: begin
          if (wr_accept) begin
            if (wr_first_beat) begin
              wr_addr_hold_reg <= wr_address_i;
              wr_bc_hold_reg   <= wr_burstcount_i;
              beats_left_reg   <= wr_burst_len - BEAT_ONE;
            end else begin
              beats_left_reg   <= beats_left_reg - BEAT_ONE;
            end
            if (wr_last) begin
              state_reg <= rd_read_i ? ARB_RD : ARB_IDLE;
            end
          end else if (wr_first_beat && !wr_write_i) begin
            // Writer withdrew before any beat was taken; nothing to hold
            state_reg <= rd_read_i ? ARB_RD : ARB_IDLE;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

endmodule
